// File: rtl/id_ex_unpack.sv
// rtl/id_ex_unpack.sv - ID->EX packet unpacker with 2-entry skid buffer and flush
// Optional build macro ID_EX_STATS_EN adds stall_cnt/flush_cnt counter outputs.
module id_ex_unpack #(
    parameter int DATA_W = 32,
    localparam int PKT_W = 17 + 3 * DATA_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [PKT_W-1:0]  pkt_in,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              flush,
    input  logic              out_ready,
    output logic              out_valid,
    output logic              mux_complmnt,
    output logic              mux_inp_2,
    output logic              mux_inp_1,
    output logic              mux_d_mem,
    output logic              wrten_reg,
    output logic              d_mem_r,
    output logic              d_mem_w,
    output logic              branch,
    output logic              jump,
    output logic [2:0]        alu_op,
    output logic [2:0]        fun_3,
    output logic [1:0]        mux_result,
    output logic [DATA_W-1:0] data_1,
    output logic [DATA_W-1:0] data_2,
    output logic [DATA_W-1:0] mux_1_out
`ifdef ID_EX_STATS_EN
    ,
    output logic [31:0]       stall_cnt,
    output logic [31:0]       flush_cnt
`endif
);

    localparam int C0 = 3 * DATA_W;

    typedef enum logic [1:0] {EMPTY, ONE, TWO} state_t;

    state_t            state_q, state_d;
    logic [PKT_W-1:0]  h_q, h_d;
    logic [PKT_W-1:0]  s_q, s_d;
    logic              in_ready_q, in_ready_d;
    logic              accept;
    logic              consume;

    assign accept    = in_valid & in_ready_q;
    assign out_valid = (state_q != EMPTY);
    assign consume   = out_valid & out_ready;
    assign in_ready  = in_ready_q;

    always_comb begin
        state_d = state_q;
        h_d     = h_q;
        s_d     = s_q;
        case (state_q)
            EMPTY: begin
                if (accept) begin
                    h_d     = pkt_in;
                    state_d = ONE;
                end
            end
            ONE: begin
                if (accept && consume) begin
                    h_d = pkt_in;
                end else if (accept) begin
                    s_d     = pkt_in;
                    state_d = TWO;
                end else if (consume) begin
                    state_d = EMPTY;
                end
            end
            TWO: begin
                if (consume) begin
                    h_d     = s_q;
                    state_d = ONE;
                end
            end
            default: state_d = EMPTY;
        endcase
        // Flush keeps stored words so data fields hold; dropped packets never load.
        if (flush) begin
            state_d = EMPTY;
            h_d     = h_q;
            s_d     = s_q;
        end
        in_ready_d = (state_d != TWO);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= EMPTY;
            h_q        <= '0;
            s_q        <= '0;
            in_ready_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            h_q        <= h_d;
            s_q        <= s_d;
            in_ready_q <= in_ready_d;
        end
    end

    assign mux_complmnt = h_q[C0+16];
    assign mux_inp_2    = h_q[C0+15];
    assign mux_inp_1    = h_q[C0+14];
    assign mux_d_mem    = h_q[C0+13];
    assign wrten_reg    = h_q[C0+12] & out_valid;
    assign d_mem_r      = h_q[C0+11] & out_valid;
    assign d_mem_w      = h_q[C0+10] & out_valid;
    assign branch       = h_q[C0+9]  & out_valid;
    assign jump         = h_q[C0+8]  & out_valid;
    assign alu_op       = h_q[C0+7:C0+5];
    assign fun_3        = h_q[C0+4:C0+2];
    assign mux_result   = h_q[C0+1:C0];
    assign data_1       = h_q[3*DATA_W-1:2*DATA_W];
    assign data_2       = h_q[2*DATA_W-1:DATA_W];
    assign mux_1_out    = h_q[DATA_W-1:0];

`ifdef ID_EX_STATS_EN
    logic [31:0] stall_cnt_q, stall_cnt_d;
    logic [31:0] flush_cnt_q, flush_cnt_d;
    logic [1:0]  held;
    logic [1:0]  discard;

    always_comb begin
        held = 2'd0;
        case (state_q)
            ONE:     held = 2'd1;
            TWO:     held = 2'd2;
            default: held = 2'd0;
        endcase
        // A head consumed in the flush cycle reached EX, so it is not discarded.
        discard     = flush ? (held - {1'b0, consume}) : 2'd0;
        stall_cnt_d = stall_cnt_q + {31'd0, out_valid & ~out_ready};
        flush_cnt_d = flush_cnt_q + {30'd0, discard};
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;
`endif

endmodule

// File: doc/id_ex_unpack.md
Name: id_ex_unpack

Overview:
- Receiving end of the ID→EX pipeline packet: accepts the packed ID-stage control/data word and presents individually decoded fields to the EX stage.
- Sits between the ID pipeline register and the ALU/branch/memory-control logic.
- Holds a 2-entry skid buffer so EX back-pressure (multi-cycle ops, memory wait) never drops a packet.
- Supports flush on taken branch/jump.

Parameters:
- DATA_W, 32, width of each data field (data_1, data_2, mux_1_out).
- PKT_W, 17+3*DATA_W (113), packet width; derived, never overridden.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- pkt_in  in  PKT_W  packed ID packet, MSB→LSB: mux_complmnt, mux_inp_2, mux_inp_1, mux_d_mem, wrten_reg, d_mem_r, d_mem_w, branch, jump, alu_op[2:0], fun_3[2:0], mux_result[1:0], data_1, data_2, mux_1_out.
- in_valid  in  1  pkt_in valid.
- in_ready  out  1  block can accept a packet this cycle.
- flush  in  1  discard all held packets (taken branch/jump).
- out_ready  in  1  EX consumes the head packet this cycle.
- out_valid  out  1  head packet valid.
- mux_complmnt, mux_inp_2, mux_inp_1, mux_d_mem, wrten_reg, d_mem_r, d_mem_w, branch, jump  out  1 each  decoded head control bits.
- alu_op, fun_3  out  3 each  decoded head fields.
- mux_result  out  2  decoded head field.
- data_1, data_2, mux_1_out  out  DATA_W each  decoded head data.

Behaviour:
- Reset is asynchronous, active-high. All outputs go to 0 immediately: out_valid=0, in_ready=0 while reset is asserted, and all decoded fields =0. State is EMPTY. in_ready rises on the first clk edge after reset deasserts.
- Storage: head register H and skid register S.
- States: EMPTY (none held), ONE (H valid), TWO (H and S valid).
- Handshakes: accept = in_valid & in_ready; consume = out_valid & out_ready.
- in_ready is registered: 1 in EMPTY/ONE, 0 in TWO.
- Latency: packet accepted at edge N appears on outputs after edge N (1 cycle) when the block was EMPTY.
- Transitions (flush=0):
  - EMPTY: accept → H=pkt, ONE.
  - ONE: accept & consume → H=pkt, stay ONE. accept & !consume → S=pkt, TWO. !accept & consume → EMPTY.
  - TWO: consume → H=S, ONE (no accept possible since in_ready=0).
- Order: packets leave in acceptance order; no reorder, duplication or drop except on flush.
- Outputs: decoded fields are driven from H only, bit-exact slices of the stored packet.
- Invalid head: when out_valid=0, all decoded control bits (wrten_reg, d_mem_r, d_mem_w, branch, jump) are forced 0. Data fields hold their last value.
- flush=1 at an edge → state EMPTY, out_valid=0 next cycle. A same-cycle accept is also dropped (flush wins). A same-cycle consume is still counted as consumed by EX.
- Simultaneous flush and reset: reset dominates.
- Head stability: H must not change while out_valid=1 and out_ready=0.

Optional Feature:
- Macro ID_EX_STATS_EN.
- Defined:
  - Adds outputs stall_cnt[31:0] and flush_cnt[31:0], both reset to 0.
  - stall_cnt increments each cycle out_valid=1 & out_ready=0.
  - flush_cnt increments by the number of valid entries discarded per flush (0, 1 or 2).
  - Both counters wrap at 2^32.
- Undefined: ports absent, no counter logic.

Test Plan:
- Reset mid-stream: hold reset=1 with in_valid=1 → out_valid=0, in_ready=0 and all outputs 0 immediately; first edge after release gives in_ready=1.
- Single pass: pkt with alu_op=3'b101, data_1=32'h0000_1234, out_ready=1 → next cycle out_valid=1, alu_op=5, data_1=0x1234; following cycle out_valid=0.
- Back-pressure: out_ready=0, send packets A (data_2=1) and B (data_2=2) → in_ready=0 after B, head stays A. Raise out_ready → A then B in consecutive cycles, then in_ready=1.
- Streaming: in_valid=out_ready=1 for 10 cycles, data_1=0..9 → outputs 0..9 in order, one per cycle, in_ready never drops.
- Flush in TWO with same-cycle in_valid → next cycle out_valid=0, wrten_reg=0, d_mem_w=0. The flushed packets never appear. With ID_EX_STATS_EN defined, flush_cnt=2.
- Stats: with ID_EX_STATS_EN defined, 5 cycles out_valid=1 & out_ready=0 → stall_cnt=5.
